// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory bank responder.
//   - request width encodings (DM_W_BYTE/HALF/WORD/ILL)
//   - responder FSM state type
//   - width_bytes(): byte count n for a width code (0 for the illegal code)
package dm_pkg;

  localparam logic [1:0] DM_W_BYTE = 2'b00;
  localparam logic [1:0] DM_W_HALF = 2'b01;
  localparam logic [1:0] DM_W_WORD = 2'b10;
  localparam logic [1:0] DM_W_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } dm_state_t;

  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      DM_W_BYTE: width_bytes = 3'd1;
      DM_W_HALF: width_bytes = 3'd2;
      DM_W_WORD: width_bytes = 3'd4;
      default:   width_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_bank_responder_if.sv
// dm_bank_responder_if: valid/ready request/response bus between the
// processor-side bridge (master) and the bank responder (slave).
//   req_valid/req_ready   request handshake
//   req_we, req_width     write flag, width code (dm_pkg DM_W_*)
//   req_addr, req_wdata   byte address, LSB-aligned write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    zero-extended read data, error flag
interface dm_bank_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_width, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_width, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_byte_bank.sv
// dm_byte_bank: 8-bit x ROWS synchronous RAM, one per byte lane.
//   clk    clock
//   we     write enable (write commits on the rising edge)
//   addr   row address; registered every edge for the read port
//   wdata  write byte
//   rdata  byte at the previously registered address
// Contents are intentionally not reset.
module dm_byte_bank #(
  parameter int unsigned ROWS = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] addr,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata
);
  logic [7:0]              mem [ROWS];
  logic [$clog2(ROWS)-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    addr_q <= addr;
  end

  assign rdata = mem[addr_q];
endmodule

// File: rtl/dm_bank_responder.sv
// dm_bank_responder: valid/ready slave serving byte/half/word accesses
// (unaligned allowed, row crossing in a single bank cycle) from four
// byte-wide banks; lane i holds bytes with offset mod 4 == i.
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   dm_bank_responder_if.slave request/response bus
// Optional build macro: DM_BOUNDS_CHECK_EN -- when defined, accesses with
// off + n > 4*ROWS are rejected; otherwise rows wrap modulo ROWS.
module dm_bank_responder
  import dm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned ROWS      = 16
) (
  input  logic                clk,
  input  logic                rst,
  dm_bank_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(ROWS);

  dm_state_t   state;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [1:0]  lane_q;
  logic [2:0]  n_q;

  logic [31:0] off;
  logic [1:0]  lane;
  logic [AW-1:0] row;
  logic [2:0]  n;
  logic        req_err;
  logic        accept;
  logic [3:0]  bank_we;
  logic [AW-1:0] bank_addr  [4];
  logic [7:0]  bank_wdata [4];
  logic [7:0]  bank_rdata [4];
  logic [31:0] rd_data;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    off     = bus.req_addr - BASE_ADDR;
    lane    = off[1:0];
    row     = off[AW+1:2];
    n       = width_bytes(bus.req_width);
    req_err = (bus.req_width == DM_W_ILL);
`ifdef DM_BOUNDS_CHECK_EN
    if (({1'b0, off} + 33'(n)) > 33'(4 * ROWS)) req_err = 1'b1;
`endif
    accept  = bus.req_valid & ready_q;
    // Lane i carries access byte k = (i - lane) mod 4; lanes below the start
    // lane belong to the next row.
    for (int unsigned i = 0; i < 4; i++) begin
      bank_addr[i]  = (2'(i) < lane) ? row + AW'(1) : row;
      bank_wdata[i] = 8'(bus.req_wdata >> {2'(2'(i) - lane), 3'b000});
      bank_we[i]    = accept & bus.req_we & ~req_err & ~rst &
                      ({1'b0, 2'(2'(i) - lane)} < n);
    end
    // Rotate lane outputs back by the captured start lane and mask to n bytes.
    rd_data = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (3'(j) < n_q) rd_data[8*j +: 8] = bank_rdata[2'(2'(j) + lane_q)];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dm_byte_bank #(.ROWS(ROWS)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .addr  (bank_addr[g]),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      lane_q  <= '0;
      n_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            lane_q  <= lane;
            n_q     <= n;
            err_q   <= req_err;
            rdata_q <= '0;
            if (bus.req_we || req_err) begin
              valid_q <= 1'b1;
              state   <= RSP;
            end else begin
              state   <= RD;
            end
          end
        end
        RD: begin
          rdata_q <= rd_data;
          valid_q <= 1'b1;
          state   <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dm_bank_responder.md
# dm_bank_responder

Memory-side responder for the processor data-memory port. Accepts byte, halfword and word requests from the processor-side bridge and serves them from four byte-wide synchronous banks; lane `i` holds bytes whose offset mod 4 equals `i`. Unaligned accesses are served in one bank cycle, including accesses that cross a row. Reads are zero-extended. The block replaces the loose tri-state byte RAMs with a single valid/ready slave.

## Interface
- `BASE_ADDR`, 32'h0000_1000, first byte address decoded by this block.
- `ROWS`, 16, entries per bank; capacity is 4*ROWS bytes; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; reset 0, then 1 in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_width`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data, LSB-aligned.
- `rsp_valid`  out  1  response present; reset 0.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  zero-extended read data; 0 for writes and errors; reset 0.
- `rsp_err`  out  1  request rejected; reset 0.

## Operation
- Address rules:
  - `off = req_addr - BASE_ADDR` (32-bit, modulo 2^32).
  - Byte `k` of an access (k < n; n = 1/2/4 by width) goes to lane `(off+k)[1:0]` and row `(off+k)>>2`.
  - Lanes below the start lane use `row+1` when the access crosses a row.
- Error rules:
  - `req_width == 11` is always an error.
  - With bounds checking compiled in, `off + n > 4*ROWS` is also an error.
  - An errored request writes no bank and returns `rsp_err=1`, `rsp_rdata=0`.
- Writes: byte `k` of `req_wdata` is written to its lane/row. The bank write enable is asserted only for the n touched lanes.
- Reads: lane outputs are rotated back by the start lane, then masked to n bytes.
- FSM states:
  - IDLE: `req_ready=1`.
    - Accepted write or error → RSP.
    - Accepted read → RD.
  - RD: bank data is valid. Register the rotated and masked data into `rsp_rdata`. → RSP.
  - RSP: `rsp_valid=1`; response held stable until `rsp_ready`. On `rsp_valid & rsp_ready` → IDLE.
- Capture: all request fields are captured on the accept edge. `req_*` is ignored outside IDLE.

## Timing
- Accept: rising edge with `req_valid & req_ready`.
- Write: bank write commits on the accept edge; `rsp_valid` is high the following cycle.
- Read: bank address is registered on the accept edge; `rsp_valid` is high 2 cycles after accept.
- Throughput: one request every 2 cycles for writes and 3 for reads. Zero-wait `rsp_ready` is assumed for these numbers.
- Back-pressure: while `rsp_ready=0`, the block stays in RSP and `req_ready` stays 0.
- Read-after-write to the same byte returns the new data, since the write completed before the next accept.
- `rst` mid-operation: FSM → IDLE; all outputs take their reset values; any pending response is dropped.
- Bank contents are not cleared by reset. A write whose accept edge coincides with `rst` assertion does not commit.

## Configuration
- `DM_BOUNDS_CHECK_EN`:
  - Defined: out-of-range accesses produce `rsp_err`.
  - Undefined: rows wrap modulo ROWS, so a row crossing past the last row continues at row 0, and only width 11 errors.

## Structure
- Package `dm_pkg`:
  - Width encodings `DM_W_BYTE/HALF/WORD/ILL`.
  - FSM state enum `{IDLE, RD, RSP}`.
  - Function returning byte count n for a width.
- Sub-module `dm_byte_bank`: 8-bit × ROWS synchronous RAM with write enable and registered read address. Instantiated 4 times, once per lane.

## Test plan
- Word write 0xDEADBEEF @0x1000, then word read @0x1000 → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`; read `rsp_valid` exactly 2 cycles after accept.
- Byte write 0xAA @0x1005, then half read @0x1004 → 0x0000AA00 when byte 0x1004 was previously 0; word @0x1004 shows only lane 1 changed.
- Unaligned word write 0x11223344 @0x1003, then word read @0x1003 → 0x11223344. Row crossing is handled and lanes 0..2 land in row 1.
- Errors:
  - `req_width=11` → `rsp_err=1`, `rsp_rdata=0`, memory unchanged.
  - With `DM_BOUNDS_CHECK_EN`, word @0x103E → `rsp_err=1`.
  - Without it, @0x103E wraps to row 0 with no error.
- Hold `rsp_ready=0` for 5 cycles after a read → `rsp_valid` and `rsp_rdata` stable, `req_ready=0`; release → IDLE next cycle.
- Assert `rst` while in RD → `rsp_valid=0`, `req_ready` returns to 1 after deassert; previously written data is still readable.
